csr_counter_file: RTL and testbench

Parametrised counter/CSR file for the RISC-V core: holds cycle, time, instret, a configurable bank of hardware performance counters, mhartid and mcountinhibit. Retire-stage CSR reads are served combinationally from live counter state; Machine-mode writes take effect at the clock edge. Sits beside the WB stage and is fed retire and event strobes from the pipeline.

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_counter.sv | 35 +++
 rtl/csr_counter_file.sv | 182 ++++++++++++++++++
 tb/tb_csr_counter_file.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, counter slot indices and mcountinhibit layout for the
// counter/CSR file beside the WB stage.
package csr_pkg;

    localparam logic [11:0] CSR_USER_LO_BASE  = 12'hC00;
    localparam logic [11:0] CSR_USER_HI_BASE  = 12'hC80;
    localparam logic [11:0] CSR_MACH_LO_BASE  = 12'hB00;
    localparam logic [11:0] CSR_MACH_HI_BASE  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // Low five address bits select the counter inside each 32-entry range
    localparam logic [4:0] CNT_IDX_CYCLE   = 5'd0;
    localparam logic [4:0] CNT_IDX_TIME    = 5'd1;
    localparam logic [4:0] CNT_IDX_INSTRET = 5'd2;
    localparam int         CNT_IDX_HPM_BASE = 3;

    localparam int INH_CY       = 0;
    localparam int INH_TM       = 1;
    localparam int INH_IR       = 2;
    localparam int INH_HPM_BASE = 3;

    typedef enum logic [1:0] {
        CSR_KIND_NONE,
        CSR_KIND_COUNTER,
        CSR_KIND_HARTID,
        CSR_KIND_INHIBIT
    } csr_kind_e;

    // Time can never be inhibited, so TM stays a hard zero in the mask
    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m         = '0;
        m[INH_CY] = 1'b1;
        m[INH_TM] = 1'b0;
        m[INH_IR] = 1'b1;
        for (int i = 0; i < num_hpm; i++) begin
            m[INH_HPM_BASE + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_W-bit counter with independently writable 32-bit lo/hi halves;
// a write to either half takes precedence over the increment that cycle.
module csr_counter
    import csr_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] count
);

    localparam int HI_W = CNT_W - 32;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                count[31:0] <= wdata;
            end
            if (wr_hi) begin
                count[CNT_W-1:32] <= wdata[HI_W-1:0];
            end
        end else if (inc && !inhibit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_counter_file.sv
// Counter/CSR file: cycle, time, instret, HPM bank, mhartid and mcountinhibit,
// with combinational reads of pre-edge state and edge-applied Machine writes.
module csr_counter_file
    import csr_pkg::*;
#(
    parameter int CNT_W    = 64,
    parameter int NUM_HPM  = 2,
    parameter int TIME_DIV = 1,
    parameter int HART_ID  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               retire_valid,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               csr_rd_en,
    input  logic               csr_wr_en,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal
);

    localparam int          HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK  = inhibit_mask(NUM_HPM);

    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;
    logic [CNT_W-1:0] time_count;
    logic [CNT_W-1:0] hpm_count [HPM_SLOTS];

    logic [31:0] mcountinhibit;
    logic [31:0] prescaler;
    logic        time_tick;

    logic [11:0] addr_base;
    logic [4:0]  idx;
    logic        user_lo, user_hi, mach_lo, mach_hi;
    logic        in_user, in_mach, is_hi;

    csr_kind_e        kind;
    logic             read_only;
    logic [CNT_W-1:0] cnt_value;
    logic [63:0]      cnt_ext;
    logic [31:0]      sel_value;
    logic             wr_ok;
    logic             wr_cnt_lo, wr_cnt_hi;

    assign addr_base = {csr_addr[11:5], 5'b0};
    assign idx       = csr_addr[4:0];
    assign user_lo   = (addr_base == CSR_USER_LO_BASE);
    assign user_hi   = (addr_base == CSR_USER_HI_BASE);
    assign mach_lo   = (addr_base == CSR_MACH_LO_BASE);
    assign mach_hi   = (addr_base == CSR_MACH_HI_BASE);
    assign in_user   = user_lo | user_hi;
    assign in_mach   = mach_lo | mach_hi;
    assign is_hi     = user_hi | mach_hi;

    // Address decode: classify the access and pick the addressed counter
    always_comb begin
        kind      = CSR_KIND_NONE;
        read_only = 1'b0;
        cnt_value = '0;
        if (in_user || in_mach) begin
            read_only = in_user;
            if (idx == CNT_IDX_CYCLE) begin
                kind      = CSR_KIND_COUNTER;
                cnt_value = cycle_count;
            end else if (idx == CNT_IDX_TIME && in_user) begin
                kind      = CSR_KIND_COUNTER;
                cnt_value = time_count;
            end else if (idx == CNT_IDX_INSTRET) begin
                kind      = CSR_KIND_COUNTER;
                cnt_value = instret_count;
            end else begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (int'(idx) == CNT_IDX_HPM_BASE + i) begin
                        kind      = CSR_KIND_COUNTER;
                        cnt_value = hpm_count[i];
                    end
                end
            end
        end else if (csr_addr == CSR_MHARTID) begin
            kind      = CSR_KIND_HARTID;
            read_only = 1'b1;
        end else if (csr_addr == CSR_MCOUNTINHIBIT) begin
            kind = CSR_KIND_INHIBIT;
        end
    end

    // Read mux; the hi half is zero-extended when CNT_W is below 64
    always_comb begin
        cnt_ext   = 64'(cnt_value);
        sel_value = '0;
        case (kind)
            CSR_KIND_COUNTER: sel_value = is_hi ? cnt_ext[63:32] : cnt_ext[31:0];
            CSR_KIND_HARTID:  sel_value = 32'(HART_ID);
            CSR_KIND_INHIBIT: sel_value = mcountinhibit;
            default:          sel_value = '0;
        endcase
    end

    assign csr_illegal = (csr_rd_en || csr_wr_en) &&
                         ((kind == CSR_KIND_NONE) || (csr_wr_en && read_only));
    assign csr_rdata   = (csr_rd_en && !csr_illegal) ? sel_value : 32'd0;

    assign wr_ok     = csr_wr_en && !csr_illegal;
    assign wr_cnt_lo = wr_ok && (kind == CSR_KIND_COUNTER) && mach_lo;
    assign wr_cnt_hi = wr_ok && (kind == CSR_KIND_COUNTER) && mach_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcountinhibit <= '0;
        end else if (wr_ok && kind == CSR_KIND_INHIBIT) begin
            mcountinhibit <= csr_wdata & INH_MASK;
        end
    end

    assign time_tick = (prescaler == 32'(TIME_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (time_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .inhibit (mcountinhibit[INH_CY]),
        .wr_lo   (wr_cnt_lo && idx == CNT_IDX_CYCLE),
        .wr_hi   (wr_cnt_hi && idx == CNT_IDX_CYCLE),
        .wdata   (csr_wdata),
        .count   (cycle_count)
    );

    csr_counter #(.CNT_W(CNT_W)) u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (retire_valid),
        .inhibit (mcountinhibit[INH_IR]),
        .wr_lo   (wr_cnt_lo && idx == CNT_IDX_INSTRET),
        .wr_hi   (wr_cnt_hi && idx == CNT_IDX_INSTRET),
        .wdata   (csr_wdata),
        .count   (instret_count)
    );

    // Time has no machine alias, so it is never written
    csr_counter #(.CNT_W(CNT_W)) u_time (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (time_tick),
        .inhibit (1'b0),
        .wr_lo   (1'b0),
        .wr_hi   (1'b0),
        .wdata   (csr_wdata),
        .count   (time_count)
    );

    generate
        if (NUM_HPM == 0) begin : g_no_hpm
            assign hpm_count[0] = '0;
        end
        for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
            csr_counter #(.CNT_W(CNT_W)) u_hpm (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc     (hpm_event[i]),
                .inhibit (mcountinhibit[INH_HPM_BASE + i]),
                .wr_lo   (wr_cnt_lo && int'(idx) == CNT_IDX_HPM_BASE + i),
                .wr_hi   (wr_cnt_hi && int'(idx) == CNT_IDX_HPM_BASE + i),
                .wdata   (csr_wdata),
                .count   (hpm_count[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_csr_counter_file.sv
// Scoreboard bench for csr_counter_file: each step pushes its expected
// {rdata, illegal} when driven, and each scenario task pops and compares.
module tb_csr_counter_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire_valid = 1'b0;
    logic [1:0]  hpm_event = 2'b00;
    logic        csr_rd_en = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    int tests_run = 0;
    int tests_failed = 0;

    logic [32:0] exp_q [$];
    logic [32:0] obs_q [$];
    string       name_q [$];

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        retire;
        logic [1:0]  hpm;
        logic        chk;
        logic [31:0] er;
        logic        ei;
    } step_t;

    csr_counter_file #(
        .CNT_W    (64),
        .NUM_HPM  (2),
        .TIME_DIV (4),
        .HART_ID  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_valid (retire_valid),
        .hpm_event    (hpm_event),
        .csr_rd_en    (csr_rd_en),
        .csr_wr_en    (csr_wr_en),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal)
    );

    always #5 clk = ~clk;

    function automatic step_t s_idle(input logic retire = 1'b0, input logic [1:0] hpm = 2'b00);
        step_t s;
        s = '0;
        s.retire = retire;
        s.hpm = hpm;
        return s;
    endfunction

    function automatic step_t s_idle_chk(input logic [11:0] addr);
        step_t s;
        s = '0;
        s.addr = addr;
        s.chk = 1'b1;
        return s;
    endfunction

    function automatic step_t s_read(input logic [11:0] addr, input logic [31:0] er,
                                     input logic retire = 1'b0);
        step_t s;
        s = '0;
        s.rd = 1'b1;
        s.addr = addr;
        s.retire = retire;
        s.chk = 1'b1;
        s.er = er;
        return s;
    endfunction

    function automatic step_t s_write(input logic [11:0] addr, input logic [31:0] data);
        step_t s;
        s = '0;
        s.wr = 1'b1;
        s.addr = addr;
        s.wdata = data;
        return s;
    endfunction

    function automatic step_t s_wr_rd(input logic [11:0] addr, input logic [31:0] data,
                                      input logic [31:0] er, input logic retire);
        step_t s;
        s = '0;
        s.rd = 1'b1;
        s.wr = 1'b1;
        s.addr = addr;
        s.wdata = data;
        s.retire = retire;
        s.chk = 1'b1;
        s.er = er;
        return s;
    endfunction

    function automatic step_t s_bad(input logic rd, input logic wr, input logic [11:0] addr,
                                    input logic [31:0] data);
        step_t s;
        s = '0;
        s.rd = rd;
        s.wr = wr;
        s.addr = addr;
        s.wdata = data;
        s.chk = 1'b1;
        s.er = 32'd0;
        s.ei = 1'b1;
        return s;
    endfunction

    // Drive one cycle starting at a negedge, sample 1 ns later, end on the next negedge
    task automatic run_step(input step_t s, input string name);
        csr_rd_en = s.rd;
        csr_wr_en = s.wr;
        csr_addr = s.addr;
        csr_wdata = s.wdata;
        retire_valid = s.retire;
        hpm_event = s.hpm;
        if (s.chk) begin
            exp_q.push_back({s.er, s.ei});
            name_q.push_back(name);
        end
        #1;
        if (s.chk) begin
            obs_q.push_back({csr_rdata, csr_illegal});
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int n, input logic retire = 1'b0, input logic [1:0] hpm = 2'b00);
        for (int i = 0; i < n; i++) begin
            run_step(s_idle(retire, hpm), "idle");
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        csr_rd_en = 1'b0;
        csr_wr_en = 1'b0;
        retire_valid = 1'b0;
        hpm_event = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [32:0] e, o;
        string nm;
        csr_rd_en = 1'b1;
        csr_addr = 12'hC00;
        exp_q.push_back({32'd0, 1'b0});
        name_q.push_back("reset_held_cycle");
        #1;
        obs_q.push_back({csr_rdata, csr_illegal});
        apply_reset();
        run_step(s_read(12'hC00, 32'd0), "reset_first_read");
        run_step(s_idle_chk(12'hC00), "reset_idle_outputs");
        run_idle(2);
        run_step(s_read(12'hC00, 32'd4), "reset_pre_async");
        csr_rd_en = 1'b1;
        csr_addr = 12'hC00;
        #1;
        rst_n = 1'b0;
        exp_q.push_back({32'd0, 1'b0});
        name_q.push_back("reset_async_clear");
        #1;
        obs_q.push_back({csr_rdata, csr_illegal});
        apply_reset();
        run_step(s_read(12'hC00, 32'd0), "reset_after_midrun");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_cycle_count();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_idle(10);
        run_step(s_read(12'hC00, 32'd10), "cycle_lo_10");
        run_step(s_read(12'hC80, 32'd0), "cycle_hi_0");
        run_step(s_read(12'hB00, 32'd12), "cycle_mach_alias");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_step(s_write(12'hB00, 32'hFFFF_FFFF), "wr_lo");
        run_step(s_write(12'hB80, 32'h0), "wr_hi");
        run_idle(1);
        run_step(s_read(12'hC00, 32'd0), "carry_lo");
        run_step(s_read(12'hC80, 32'd1), "carry_hi");
        run_step(s_write(12'hB80, 32'hFFFF_FFFF), "wr_hi_ones");
        run_step(s_write(12'hB00, 32'hFFFF_FFFF), "wr_lo_ones");
        run_step(s_read(12'hC80, 32'hFFFF_FFFF), "all_ones_hi");
        run_step(s_read(12'hC00, 32'd0), "wrap_lo");
        run_step(s_read(12'hC80, 32'd0), "wrap_hi");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_write_wins();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_step(s_wr_rd(12'hB02, 32'd5, 32'd0, 1'b1), "instret_same_cycle_old");
        run_step(s_read(12'hC02, 32'd5, 1'b1), "instret_write_won");
        run_idle(2, 1'b1);
        run_step(s_read(12'hC02, 32'd8), "instret_plus3");
        run_step(s_write(12'hB82, 32'd7), "wr_instret_hi");
        run_step(s_read(12'hC82, 32'd7), "instret_hi_written");
        run_step(s_read(12'hC02, 32'd8), "instret_lo_held");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_inhibit();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_step(s_write(12'h320, 32'h5), "wr_inhibit");
        run_step(s_read(12'hC00, 32'd1), "cycle_frozen_a");
        run_step(s_read(12'hC02, 32'd0, 1'b1), "instret_frozen_a");
        run_step(s_read(12'hC02, 32'd0), "instret_frozen_b");
        run_step(s_read(12'hC01, 32'd1), "time_not_inhibited");
        run_step(s_read(12'hC00, 32'd1), "cycle_frozen_b");
        run_step(s_read(12'h320, 32'h5), "inhibit_readback");
        run_step(s_write(12'h320, 32'h2), "wr_inhibit_tm");
        run_step(s_read(12'h320, 32'h0), "inhibit_tm_ignored");
        run_step(s_read(12'hC00, 32'd2), "cycle_resumed");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_hpm();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_idle(4, 1'b0, 2'b01);
        run_idle(2, 1'b0, 2'b11);
        run_step(s_read(12'hC03, 32'd6), "hpm3_count");
        run_step(s_read(12'hC04, 32'd2), "hpm4_count");
        run_step(s_write(12'h320, 32'h8), "wr_inhibit_hpm3");
        run_idle(2, 1'b0, 2'b11);
        run_step(s_read(12'hB03, 32'd6), "hpm3_inhibited");
        run_step(s_read(12'hB04, 32'd4), "hpm4_running");
        run_step(s_write(12'hB83, 32'hA), "wr_hpm3_hi");
        run_step(s_read(12'hC83, 32'hA), "hpm3_hi");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_time_prescaler();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_idle(12);
        run_step(s_read(12'hC01, 32'd3), "time_lo_div4");
        run_step(s_read(12'hC81, 32'd0), "time_hi");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [32:0] e, o;
        string nm;
        apply_reset();
        run_step(s_bad(1'b1, 1'b0, 12'hC05, 32'h0), "rd_unmapped_hpm");
        run_step(s_bad(1'b0, 1'b1, 12'hC00, 32'hABCD), "wr_user_cycle");
        run_step(s_read(12'hC00, 32'd2), "cycle_unchanged");
        run_step(s_read(12'hF14, 32'd3), "mhartid");
        run_step(s_bad(1'b0, 1'b1, 12'hF14, 32'h7), "wr_mhartid");
        run_step(s_bad(1'b1, 1'b1, 12'hC01, 32'h55), "rdwr_time");
        run_step(s_bad(1'b1, 1'b0, 12'hB01, 32'h0), "rd_mach_time");
        run_step(s_bad(1'b1, 1'b0, 12'h123, 32'h0), "rd_random_addr");
        run_step(s_idle_chk(12'hC05), "idle_no_illegal");
        run_step(s_read(12'hC01, 32'd2), "time_unchanged");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            nm = name_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                         nm, o[32:1], o[0], e[32:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cycle_count();
        test_carry_wrap();
        test_write_wins();
        test_inhibit();
        test_hpm();
        test_time_prescaler();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
